div_verify: RTL and testbench

Sequential multiply-accumulate unit that runs the divider in reverse: from a quotient `q`, divisor `y` and remainder `r` it rebuilds the dividend `x = q*y + r` using shift-add, one quotient bit per clock. It sits beside the divider in the lab design and closes the loop: `q`/`r` from a finished division go in, and the bench compares the rebuilt `x` with the original dividend. It also flags quotient/remainder pairs that no legal division could have produced.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_verify.sv | 95 +++++++++
 tb/tb_div_verify.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider and its shift-add verifier.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_verify.sv
// Rebuilds a dividend x = q*y + r by shift-add, one quotient bit per clock,
// and flags operand sets that no legal division could have produced.
module div_verify
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   r,
    output logic [2*WIDTH-1:0] x,
    output logic               overflow,
    output logic               error,
    output logic               done
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    div_state_e      state_q;
    logic [W2-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [W2-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [W2-1:0]   x_q;
    logic            ovf_q;
    logic            err_q;
    logic            done_q;

    logic [W2-1:0]   acc_d;
    logic            illegal_d;

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Operand legality is judged from the latched copies on the first CALC
    // edge, so the inputs are free to change right after the accepting edge.
    assign illegal_d = (mcand_q == '0) || (acc_q >= mcand_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, y};
                        mplier_q <= q;
                        acc_q    <= {{WIDTH{1'b0}}, r};
                        cnt_q    <= '0;
                        done_q   <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == '0 && illegal_d) begin
                        x_q     <= '0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(WIDTH)) begin
                        x_q     <= acc_q;
                        ovf_q   <= |acc_q[W2-1:WIDTH];
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x        = x_q;
    assign overflow = ovf_q;
    assign error    = err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_div_verify.sv
// Randomized and directed check of div_verify against an arithmetic model of x = q*y + r.
module tb_div_verify;
    import div_pkg::*;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   q;
    logic [W-1:0]   y;
    logic [W-1:0]   r;
    logic [2*W-1:0] x;
    logic           overflow;
    logic           error;
    logic           done;

    int n_checks = 0;
    int n_fail   = 0;

    div_verify #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q        (q),
        .y        (y),
        .r        (r),
        .x        (x),
        .overflow (overflow),
        .error    (error),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One launch with a 1-cycle start; disturb re-pulses start and scrambles
    // the operands while the computation is in flight.
    task automatic run_op(input int qi, input int yi, input int ri, input bit disturb, input string tag);
        bit exp_err;
        int exp_x;
        int exp_lat;
        int lat;
        exp_err = (yi == 0) || (ri >= yi);
        exp_x   = exp_err ? 0 : qi * yi + ri;
        exp_lat = exp_err ? 1 : W + 1;
        @(negedge clk);
        q = W'(qi); y = W'(yi); r = W'(ri); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_clr"}, 32'(done), 0);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            if (disturb && lat == 2) begin
                start = 1'b1;
                q = W'($urandom); y = W'($urandom); r = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        $display("op %s: q=%0d y=%0d r=%0d -> x=%0d ovf=%0d err=%0d lat=%0d", tag, qi, yi, ri, x, overflow, error, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_x"},   32'(x), 32'(exp_x));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_x >= (1 << W)));
        chk({tag, "_err"}, 32'(error), 32'(exp_err));
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_hold_x"},    32'(x), 32'(exp_x));
        chk({tag, "_hold_done"}, 32'(done), 1);
    endtask

    initial begin
        int yi, qi, ri;
        rst = 1'b0; start = 1'b0; q = '0; y = '0; r = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk) rst = 1'b1;

        run_op(7, 2, 1, 1'b0, "basic");
        run_op(15, 15, 14, 1'b0, "max_ovf");
        run_op(9, 0, 5, 1'b0, "y_zero");
        run_op(3, 2, 2, 1'b0, "r_ge_y");
        run_op(5, 3, 2, 1'b1, "disturb");

        // Reset two edges into CALC must abort with nothing exposed.
        @(negedge clk);
        q = 4'd5; y = 4'd3; r = 4'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        $display("mid-calc reset: x=%0d ovf=%0d err=%0d done=%0d", x, overflow, error, done);
        chk("abort_x", 32'(x), 0);
        chk("abort_ovf", 32'(overflow), 0);
        chk("abort_err", 32'(error), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk) rst = 1'b1;
        run_op(9, 7, 3, 1'b0, "after_abort");

        // start held high: one result every W+2 cycles, done high for one cycle each.
        @(negedge clk);
        q = 4'd4; y = 4'd3; r = 4'd0; start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            $display("b2b cycle %0d: done=%0d x=%0d", i, done, x);
            chk($sformatf("b2b_done_%0d", i), 32'(done), 32'((i >= W + 1) && ((i - (W + 1)) % (W + 2) == 0)));
            if (done) chk($sformatf("b2b_x_%0d", i), 32'(x), 12);
        end
        @(negedge clk) start = 1'b0;
        repeat (W + 3) @(posedge clk);

        for (int n = 0; n < 30; n++) begin
            yi = int'($urandom_range(0, 15));
            qi = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0 || yi == 0) ri = int'($urandom_range(0, 15));
            else ri = int'($urandom_range(0, yi - 1));
            run_op(qi, yi, ri, 1'b0, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
